// File: rtl/la_bridge_pkg.sv
// Purpose: shared types and constants for the LA bitstream bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: result-channel FSM state enum and the bit positions of la_flags_o.
package la_bridge_pkg;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } res_state_e;

  localparam int FLG_EMPTY = 0;
  localparam int FLG_FULL  = 1;
  localparam int FLG_OVF   = 2;

endpackage

// File: rtl/la_sync_fifo.sv
// Purpose: single-clock FIFO with wrap-bit pointers and a synchronous flush.
// Latency: a push is visible on head_o the cycle after it is accepted.
// Backpressure: none internally; the caller only pushes when not full (or when popping) and only pops when not empty.
// Ports: clk_i/rst_i clock and sync reset; flush_i clears the pointers and overrides push_i/pop_i;
//        push_i/push_data_i write; pop_i advances the head; head_o/count_o/full_o/empty_o report state.
module la_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define which entries are live.
  // On push+pop while full, the write slot equals the slot being read this cycle,
  // which is safe because head_o reflects the pre-edge contents.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // Same index, opposite wrap bit: the writer is exactly one lap ahead.
  assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});

endmodule

// File: rtl/la_bitstream_bridge.sv
// Purpose: LA-bit bridge feeding host bitstream words to the decoder and returning decoder results.
// Latency: host toggle at cycle N -> word on m_data_o at N+1 (empty FIFO); result visible on la_res_o 1 cycle after handshake.
// Backpressure: host writes to a full FIFO are dropped and set a sticky overflow flag; results stall (res_ready_o=0) until the host echoes the toggle.
// Ports: wb_clk_i/wb_rst_i clock and sync reset; la_* host side (enable, flush, write word + toggle,
//        result + toggle/ack, level, flags {ovf, full, empty}); m_* decoder input stream; res_* decoder result stream.
module la_bitstream_bridge
  import la_bridge_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int RES_W  = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   la_en_i,
  input  logic                   la_flush_i,
  input  logic [DATA_W-1:0]      la_data_i,
  input  logic                   la_tog_i,
  output logic [DATA_W-1:0]      m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  input  logic [RES_W-1:0]       res_data_i,
  input  logic                   res_valid_i,
  output logic                   res_ready_o,
  output logic [RES_W-1:0]       la_res_o,
  output logic                   la_res_tog_o,
  input  logic                   la_res_ack_i,
  output logic [$clog2(DEPTH):0] la_level_o,
  output logic [2:0]             la_flags_o
);

  logic             tog_q;
  logic             wr_evt;
  logic             push_req, push_acc, pop;
  logic             ovf_q, ovf_d;
  logic             fifo_full, fifo_empty;
  res_state_e       state_q;
  logic [RES_W-1:0] res_q;
  logic             res_tog_q;

  // tog_q follows the pin unconditionally (also in reset), so an edge seen while
  // disabled is consumed rather than replayed when la_en_i rises.
  always_ff @(posedge wb_clk_i) begin
    tog_q <= la_tog_i;
  end

  assign wr_evt   = la_tog_i ^ tog_q;
  assign push_req = wr_evt && la_en_i && !la_flush_i;
  assign pop      = m_valid_o && m_ready_i && !la_flush_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_acc = push_req && (!fifo_full || pop);

  always_comb begin
    ovf_d = ovf_q;
    if (la_flush_i)                 ovf_d = 1'b0;
    else if (push_req && !push_acc) ovf_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  la_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .flush_i     (la_flush_i),
    .push_i      (push_acc),
    .push_data_i (la_data_i),
    .pop_i       (pop),
    .head_o      (m_data_o),
    .count_o     (la_level_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign m_valid_o             = !fifo_empty;
  assign la_flags_o[FLG_OVF]   = ovf_q;
  assign la_flags_o[FLG_FULL]  = fifo_full;
  assign la_flags_o[FLG_EMPTY] = fifo_empty;

  // Held low during reset so no result is taken while the FSM is being cleared.
  assign res_ready_o = (state_q == R_IDLE) && la_en_i && !wb_rst_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= R_IDLE;
      res_q     <= '0;
      res_tog_q <= 1'b0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (res_valid_i && res_ready_o) begin
            res_q     <= res_data_i;
            res_tog_q <= ~res_tog_q;
            state_q   <= R_WAIT;
          end
        end
        R_WAIT: begin
          // Completes on the host echo regardless of la_en_i.
          if (la_res_ack_i == res_tog_q) state_q <= R_IDLE;
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign la_res_o     = res_q;
  assign la_res_tog_o = res_tog_q;

endmodule

// File: tb/tb_la_bitstream_bridge.sv
module tb_la_bitstream_bridge;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int RES_W  = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              la_en_i;
  logic              la_flush_i;
  logic [DATA_W-1:0] la_data_i;
  logic              la_tog_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [RES_W-1:0]  res_data_i;
  logic              res_valid_i;
  logic              res_ready_o;
  logic [RES_W-1:0]  la_res_o;
  logic              la_res_tog_o;
  logic              la_res_ack_i;
  logic [LVL_W-1:0]  la_level_o;
  logic [2:0]        la_flags_o;

  la_bitstream_bridge #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RES_W  (RES_W)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .la_en_i      (la_en_i),
    .la_flush_i   (la_flush_i),
    .la_data_i    (la_data_i),
    .la_tog_i     (la_tog_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .res_data_i   (res_data_i),
    .res_valid_i  (res_valid_i),
    .res_ready_o  (res_ready_o),
    .la_res_o     (la_res_o),
    .la_res_tog_o (la_res_tog_o),
    .la_res_ack_i (la_res_ack_i),
    .la_level_o   (la_level_o),
    .la_flags_o   (la_flags_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0;
  int bad   = 0;

  // Scoreboard of words the host has written that the decoder should still receive.
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf   = 1'b0;
  logic              wr_pend = 1'b0;
  logic [DATA_W-1:0] wr_dat  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Host write: flip the toggle and present a word for the coming edge.
  task automatic wr(input logic [DATA_W-1:0] d);
    la_data_i = d;
    la_tog_i  = ~la_tog_i;
    wr_pend   = 1'b1;
    wr_dat    = d;
  endtask

  // Apply the model for the upcoming edge, advance one cycle, then check FIFO-side outputs.
  task automatic step();
    logic [2:0] exp_flags;
    if (wb_rst_i || la_flush_i) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) chk("valid_when_empty", {31'd0, m_valid_o}, 32'd0);
        else                   chk("stream_data", {16'd0, m_data_o}, {16'd0, exp_q.pop_front()});
      end
      if (wr_pend && la_en_i) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(wr_dat);
        else                      m_ovf = 1'b1;
      end
    end
    wr_pend = 1'b0;
    @(posedge wb_clk_i);
    #1;
    exp_flags = {m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0};
    chk("level", {28'd0, la_level_o}, exp_q.size());
    chk("flags", {29'd0, la_flags_o}, {29'd0, exp_flags});
    chk("m_valid", {31'd0, m_valid_o}, {31'd0, exp_q.size() != 0});
  endtask

  initial begin
    int waited;
    wb_rst_i     = 1'b1;
    la_en_i      = 1'b1;
    la_flush_i   = 1'b0;
    la_data_i    = '0;
    la_tog_i     = 1'b1;
    m_ready_i    = 1'b0;
    res_data_i   = '0;
    res_valid_i  = 1'b0;
    la_res_ack_i = 1'b0;

    // Reset with the toggle held high.
    repeat (3) step();
    chk("rst_res_ready", {31'd0, res_ready_o}, 32'd0);
    chk("rst_la_res", {24'd0, la_res_o}, 32'd0);
    chk("rst_res_tog", {31'd0, la_res_tog_o}, 32'd0);
    wb_rst_i = 1'b0;
    repeat (2) step();
    chk("post_rst_flags", {29'd0, la_flags_o}, 32'd1);

    // Fill to full, then overflow.
    for (int i = 1; i <= 8; i++) begin
      wr(DATA_W'(i));
      step();
    end
    chk("full_flags", {29'd0, la_flags_o}, 32'h2);
    wr(16'h0009);
    step();
    chk("ovf_flags", {29'd0, la_flags_o}, 32'h6);
    chk("ovf_level", {28'd0, la_level_o}, 32'd8);

    // Drain in order.
    m_ready_i = 1'b1;
    repeat (8) step();
    chk("drained_flags", {29'd0, la_flags_o}, 32'h5);

    // Clear ovf, refill, then write into a full FIFO on the same cycle as a pop.
    la_flush_i = 1'b1;
    step();
    la_flush_i = 1'b0;
    m_ready_i  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(16'h0010 + DATA_W'(i));
      step();
    end
    m_ready_i = 1'b1;
    wr(16'hBEEF);
    step();
    chk("pushpop_level", {28'd0, la_level_o}, 32'd8);
    chk("pushpop_flags", {29'd0, la_flags_o}, 32'h2);
    repeat (8) step();
    chk("pushpop_empty", {28'd0, la_level_o}, 32'd0);

    // Level 5 with ovf set, then flush while writing.
    m_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr(16'h0100 + DATA_W'(i));
      step();
    end
    m_ready_i = 1'b1;
    repeat (3) step();
    m_ready_i = 1'b0;
    chk("pre_flush_level", {28'd0, la_level_o}, 32'd5);
    chk("pre_flush_flags", {29'd0, la_flags_o}, 32'h4);
    la_flush_i = 1'b1;
    wr(16'h7777);
    step();
    la_flush_i = 1'b0;
    chk("flush_level", {28'd0, la_level_o}, 32'd0);
    chk("flush_flags", {29'd0, la_flags_o}, 32'h1);
    chk("flush_valid", {31'd0, m_valid_o}, 32'd0);
    repeat (2) step();

    // Toggle while disabled is discarded.
    la_en_i = 1'b0;
    wr(16'h1234);
    step();
    step();
    la_en_i = 1'b1;
    repeat (2) step();
    chk("disabled_level", {28'd0, la_level_o}, 32'd0);

    // Result channel.
    chk("idle_ready", {31'd0, res_ready_o}, 32'd1);
    res_data_i  = 8'hA5;
    res_valid_i = 1'b1;
    step();
    chk("res1_data", {24'd0, la_res_o}, 32'hA5);
    chk("res1_tog", {31'd0, la_res_tog_o}, 32'd1);
    chk("res1_ready", {31'd0, res_ready_o}, 32'd0);
    res_data_i = 8'h3C;
    repeat (3) step();
    chk("stall_data", {24'd0, la_res_o}, 32'hA5);
    chk("stall_ready", {31'd0, res_ready_o}, 32'd0);
    la_res_ack_i = 1'b1;
    waited = 0;
    while (la_res_tog_o !== 1'b0 && waited < 6) begin
      step();
      waited++;
    end
    chk("res2_latency_ok", {31'd0, waited <= 2}, 32'd1);
    chk("res2_data", {24'd0, la_res_o}, 32'h3C);
    chk("res2_tog", {31'd0, la_res_tog_o}, 32'd0);
    res_valid_i  = 1'b0;
    la_res_ack_i = 1'b0;
    repeat (2) step();
    chk("res_ready_again", {31'd0, res_ready_o}, 32'd1);

    // Mid-operation reset loses FIFO contents.
    m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr(16'h0A00 + DATA_W'(i));
      step();
    end
    chk("pre_rst_level", {28'd0, la_level_o}, 32'd3);
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    step();
    chk("mid_rst_level", {28'd0, la_level_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
